// File: rtl/wb_port_counter_if.sv
// Wishbone target bundle for wb_port_counter.
// Signal names keep the Caravel user-port spelling.
interface wb_port_counter_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_port_counter.sv
// Wishbone-loadable free-running counter driven onto the user I/O pads.
// Define LA_CTRL_EN to add per-bit logic-analyzer override of the count.
module wb_port_counter #(
    parameter int          BITS      = 16,
    parameter int          DELAYS    = 2,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_port_counter_if.slave wbs,
    output logic [BITS-1:0] io_out,
    output logic [BITS-1:0] io_oeb,
    output logic [2:0]      irq
`ifdef LA_CTRL_EN
    ,
    input  logic [BITS-1:0] la_data_in,
    input  logic [BITS-1:0] la_oenb,
    output logic [BITS-1:0] la_data_out
`endif
);

    localparam logic [3:0] DLY_LOAD = 4'(DELAYS - 1);
    localparam logic [7:0] OFF_COUNT  = 8'h00;
    localparam logic [7:0] OFF_CTRL   = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  dly_reg, dly_next;
    logic        ack_reg, ack_next;
    logic [31:0] rdata_reg, rdata_next;

    logic [BITS-1:0] count_reg, count_next, count_base;
    logic            en_reg, en_next;
    logic            ovf_reg, ovf_next;
    logic            irq0_reg;
    logic [BITS-1:0] oeb_reg;

    logic        req;
    logic        hit;
    logic [7:0]  offset;
    logic [31:0] count_ext;
    logic [31:0] read_data;
    logic [31:0] byte_mask;
    logic [31:0] merged;
    logic        commit;
    logic        count_wr;
    logic        ctrl_wr;
    logic        status_clr;
    logic        inc_en;
    logic        wrap;
    logic        unused_merged;

    assign req    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign hit    = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign offset = wbs.wbs_adr_i[7:0];

    always_comb begin
        count_ext = '0;
        count_ext[BITS-1:0] = count_reg;
    end

    always_comb begin
        read_data = '0;
        case (offset)
            OFF_COUNT:  read_data = count_ext;
            OFF_CTRL:   read_data = {31'd0, en_reg};
            OFF_STATUS: read_data = {31'd0, ovf_reg};
            default:    read_data = '0;
        endcase
    end

    // Transaction FSM: accept, wait out the delay, ack for one cycle.
    always_comb begin
        state_next = state_reg;
        dly_next   = dly_reg;
        ack_next   = 1'b0;
        rdata_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (req && hit) begin
                    state_next = ST_WAIT;
                    dly_next   = DLY_LOAD;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (dly_reg == 4'd0) begin
                    state_next = ST_ACK;
                    ack_next   = 1'b1;
                    rdata_next = read_data;
                end else begin
                    dly_next = dly_reg - 4'd1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            dly_reg   <= '0;
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            dly_reg   <= dly_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
        end
    end

    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = rdata_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
        assign byte_mask[gi*8 +: 8] = {8{wbs.wbs_sel_i[gi]}};
    end

    // Writes land at the end of the ack cycle, so they are seen the cycle after.
    assign commit     = (state_reg == ST_ACK) & wbs.wbs_we_i;
    assign merged     = (count_ext & ~byte_mask) | (wbs.wbs_dat_i & byte_mask);
    assign count_wr   = commit & (offset == OFF_COUNT);
    assign ctrl_wr    = commit & (offset == OFF_CTRL) & wbs.wbs_sel_i[0];
    assign status_clr = commit & (offset == OFF_STATUS) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
    assign unused_merged = ^merged;

    assign inc_en = en_reg & ~count_wr;
    assign wrap   = inc_en & (&count_reg);

    always_comb begin
        count_base = count_reg;
        if (count_wr) begin
            count_base = merged[BITS-1:0];
        end else if (inc_en) begin
            count_base = count_reg + 1'b1;
        end
    end

`ifdef LA_CTRL_EN
    assign count_next  = (count_base & la_oenb) | (la_data_in & ~la_oenb);
    assign la_data_out = count_reg;
`else
    assign count_next  = count_base;
`endif

    // A wrap in the same cycle as a clear leaves OVF set.
    always_comb begin
        ovf_next = ovf_reg;
        if (status_clr) begin
            ovf_next = 1'b0;
        end
        if (wrap) begin
            ovf_next = 1'b1;
        end
    end

    assign en_next = ctrl_wr ? wbs.wbs_dat_i[0] : en_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_reg <= '0;
            en_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            irq0_reg  <= 1'b0;
            oeb_reg   <= '1;
        end else begin
            count_reg <= count_next;
            en_reg    <= en_next;
            ovf_reg   <= ovf_next;
            irq0_reg  <= wrap;
            oeb_reg   <= '0;
        end
    end

    assign io_out = count_reg;
    assign io_oeb = oeb_reg;
    assign irq    = {2'b00, irq0_reg};

endmodule

// File: tb/tb_wb_port_counter.sv
// Directed bench for wb_port_counter: register access, counting, overflow,
// byte enables, decode window, abort and reset mid-transaction.
module tb_wb_port_counter;
    localparam int BITS   = 16;
    localparam int DELAYS = 2;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic [BITS-1:0] io_out;
    logic [BITS-1:0] io_oeb;
    logic [2:0]      irq;

    int total = 0;
    int bad   = 0;

    wb_port_counter_if bus ();

    wb_port_counter #(
        .BITS     (BITS),
        .DELAYS   (DELAYS),
        .BASE_ADDR(32'h3000_0000)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .wbs     (bus.slave),
        .io_out  (io_out),
        .io_oeb  (io_oeb),
        .irq     (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Drives one request and waits up to 20 cycles for ack; caller starts just after a rising edge.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic ok, output int lat,
                           output logic [31:0] rd);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        ok  = 1'b0;
        lat = 0;
        rd  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge wb_clk_i);
            if (bus.wbs_ack_o === 1'b1) begin
                ok = 1'b1;
                rd = bus.wbs_dat_o;
                break;
            end
            lat++;
        end
        @(posedge wb_clk_i);
        #1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        $display("xfer we=%0d adr=%h dat=%h sel=%h ack=%0d lat=%0d rd=%h", we, adr, dat, sel, ok, lat, rd);
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        total++;
        if (io_oeb !== 16'hFFFF) begin bad++; $display("FAIL reset_oeb got=%h exp=ffff", io_oeb); end
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        total++;
        if (io_oeb !== 16'h0000) begin bad++; $display("FAIL oeb_after_release got=%h exp=0000", io_oeb); end
        total++;
        if (io_out !== 16'h0000) begin bad++; $display("FAIL reset_io_out got=%h exp=0000", io_out); end
        total++;
        if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.wbs_ack_o); end
        total++;
        if (irq !== 3'b000) begin bad++; $display("FAIL reset_irq got=%b exp=000", irq); end
        total++;
        if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", bus.wbs_dat_o); end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_write_read();
        logic ok; int lat; logic [31:0] rd;
        wb_xfer(1'b1, 32'h3000_0000, 32'h0000_AB60, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b1 || lat != DELAYS + 1) begin bad++; $display("FAIL write_latency ack=%b lat=%0d exp_lat=%0d", ok, lat, DELAYS + 1); end
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            total++;
            if (io_out !== 16'hAB60) begin bad++; $display("FAIL count_stable got=%h exp=ab60", io_out); end
        end
        total++;
        if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL dat_idle got=%h exp=0", bus.wbs_dat_o); end
        @(posedge wb_clk_i);
        #1;
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b1 || lat != DELAYS + 1 || rd !== 32'h0000_AB60) begin bad++; $display("FAIL read_count ack=%b lat=%0d got=%h exp=0000ab60", ok, lat, rd); end
    endtask

    task automatic test_enable_count();
        logic ok; int lat; logic [31:0] rd;
        wb_xfer(1'b1, 32'h3000_0004, 32'h1, 4'hF, ok, lat, rd);
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            total++;
            if (io_out !== 16'(16'hAB60 + i)) begin bad++; $display("FAIL count_inc step=%0d got=%h exp=%h", i, io_out, 16'(16'hAB60 + i)); end
        end
        @(posedge wb_clk_i);
        #1;
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b1 || rd !== 32'h1) begin bad++; $display("FAIL read_ctrl ack=%b got=%h exp=00000001", ok, rd); end
        wb_xfer(1'b1, 32'h3000_0004, 32'h0, 4'hF, ok, lat, rd);
        wb_xfer(1'b1, 32'h3000_0000, 32'h0000_AB61, 4'hF, ok, lat, rd);
        repeat (2) @(negedge wb_clk_i);
        total++;
        if (io_out !== 16'hAB61) begin bad++; $display("FAIL count_ab61 got=%h exp=ab61", io_out); end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_overflow();
        logic ok; int lat; logic [31:0] rd;
        logic [15:0] exp_cnt [4];
        logic        exp_irq [4];
        exp_cnt = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_irq = '{1'b0, 1'b0, 1'b1, 1'b0};
        wb_xfer(1'b1, 32'h3000_0000, 32'h0000_FFFE, 4'hF, ok, lat, rd);
        wb_xfer(1'b1, 32'h3000_0004, 32'h1, 4'hF, ok, lat, rd);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            total++;
            if (io_out !== exp_cnt[i] || irq !== {2'b00, exp_irq[i]}) begin
                bad++; $display("FAIL wrap step=%0d count=%h irq=%b exp_count=%h exp_irq0=%b", i, io_out, irq, exp_cnt[i], exp_irq[i]);
            end
        end
        @(posedge wb_clk_i);
        #1;
        wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b1 || rd !== 32'h1) begin bad++; $display("FAIL status_set ack=%b got=%h exp=00000001", ok, rd); end
        wb_xfer(1'b1, 32'h3000_0004, 32'h0, 4'hF, ok, lat, rd);
        wb_xfer(1'b1, 32'h3000_0008, 32'h0, 4'hF, ok, lat, rd);
        wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL status_sticky got=%h exp=00000001", rd); end
        wb_xfer(1'b1, 32'h3000_0008, 32'h1, 4'hF, ok, lat, rd);
        wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL status_clear ack=%b got=%h exp=00000000", ok, rd); end
    endtask

    task automatic test_byte_sel();
        logic ok; int lat; logic [31:0] rd;
        wb_xfer(1'b1, 32'h3000_0000, 32'h0000_AB60, 4'hF, ok, lat, rd);
        wb_xfer(1'b1, 32'h3000_0000, 32'h0000_1234, 4'b0001, ok, lat, rd);
        @(negedge wb_clk_i);
        total++;
        if (io_out !== 16'hAB34) begin bad++; $display("FAIL sel_byte0 got=%h exp=ab34", io_out); end
        @(posedge wb_clk_i);
        #1;
        wb_xfer(1'b1, 32'h3000_0000, 32'h00FF_CD99, 4'b0010, ok, lat, rd);
        @(negedge wb_clk_i);
        total++;
        if (io_out !== 16'hCD34) begin bad++; $display("FAIL sel_byte1 got=%h exp=cd34", io_out); end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_decode();
        logic ok; int lat; logic [31:0] rd;
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped_read ack=%b got=%h exp=00000000", ok, rd); end
        wb_xfer(1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'hF, ok, lat, rd);
        @(negedge wb_clk_i);
        total++;
        if (io_out !== 16'hCD34) begin bad++; $display("FAIL unmapped_write count=%h exp=cd34", io_out); end
        @(posedge wb_clk_i);
        #1;
        wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b0) begin bad++; $display("FAIL out_of_window ack=%b exp=0", ok); end
    endtask

    task automatic test_abort();
        int acks = 0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = 32'h3000_0000;
        bus.wbs_dat_i = 32'h0000_5555;
        bus.wbs_sel_i = 4'hF;
        @(posedge wb_clk_i);
        #1;
        bus.wbs_stb_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            if (bus.wbs_ack_o === 1'b1) acks++;
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        $display("xfer aborted write adr=30000000 dat=00005555 acks=%0d", acks);
        total++;
        if (acks != 0 || io_out !== 16'hCD34) begin bad++; $display("FAIL abort acks=%0d count=%h exp_acks=0 exp_count=cd34", acks, io_out); end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_reset_mid();
        logic ok; int lat; logic [31:0] rd;
        int acks = 0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h3000_0000;
        bus.wbs_sel_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk_i);
            if (bus.wbs_ack_o === 1'b1) acks++;
            @(posedge wb_clk_i);
            #1;
            if (i == 0) wb_rst_i = 1'b1;
            if (i == 2) begin
                wb_rst_i = 1'b0;
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
            end
        end
        $display("xfer read interrupted by reset acks=%0d", acks);
        total++;
        if (acks != 0) begin bad++; $display("FAIL reset_mid_ack acks=%0d exp=0", acks); end
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, ok, lat, rd);
        total++;
        if (ok !== 1'b1 || lat != DELAYS + 1 || rd !== 32'h0) begin bad++; $display("FAIL post_reset_read ack=%b lat=%0d got=%h exp=00000000", ok, lat, rd); end
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        test_reset();
        test_write_read();
        test_enable_count();
        test_overflow();
        test_byte_sel();
        test_decode();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
